// File: rtl/render_fb_pkg.sv
// Shared window geometry, state encoding and pixel type for the render frame-buffer writer.
// FB_DITHER_EN adds the 2x2 ordered-dither bias table used by fb_quantize.
package render_fb_pkg;

    localparam int FB_START_X = 390;
    localparam int FB_START_Y = 390;
    localparam int FB_END_X   = 634;
    localparam int FB_END_Y   = 765;

    localparam int W     = FB_END_X - FB_START_X;
    localparam int H     = FB_END_Y - FB_START_Y;
    localparam int DEPTH = W * H;

    typedef enum logic {FILL, HOLD} fb_state_t;

    typedef logic [11:0] pixel12_t;

`ifdef FB_DITHER_EN
    // Index is {row parity, column parity} of the pixel being written.
    function automatic logic [7:0] dither_bias(input logic [1:0] idx);
        case (idx)
            2'b00:   return 8'd0;
            2'b01:   return 8'd8;
            2'b10:   return 8'd12;
            default: return 8'd4;
        endcase
    endfunction
`endif

endpackage

// File: rtl/fb_quantize.sv
// Combinational 24-bit RGB to 12-bit 4:4:4 converter.
// With FB_DITHER_EN defined, a per-pixel bias is added (saturating) before truncation.
module fb_quantize import render_fb_pkg::*; (
    input  logic [23:0] rgb,
`ifdef FB_DITHER_EN
    input  logic [7:0]  bias,
`endif
    output pixel12_t    q
);

`ifdef FB_DITHER_EN
    function automatic logic [3:0] sat_hi(input logic [7:0] c, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, c} + {1'b0, b};
        return sum[8] ? 4'hF : sum[7:4];
    endfunction

    assign q = {sat_hi(rgb[23:16], bias), sat_hi(rgb[15:8], bias), sat_hi(rgb[7:0], bias)};
`else
    logic unused_lsbs;

    // Low nibbles are simply discarded when no dither is applied.
    assign unused_lsbs = ^{rgb[19:16], rgb[11:8], rgb[3:0]};
    assign q           = {rgb[23:20], rgb[15:12], rgb[7:4]};
`endif

endmodule

// File: rtl/render_fb_writer.sv
// Write side of the ping-pong renderer frame buffer: quantises tagged pixels, writes them at an
// incrementally tracked raster offset and swaps banks on new-frame. FB_DITHER_EN enables dithering.
module render_fb_writer import render_fb_pkg::*; #(
    parameter int START_X = FB_START_X,
    parameter int START_Y = FB_START_Y,
    parameter int END_X   = FB_END_X,
    parameter int END_Y   = FB_END_Y,
    parameter int ADDR_W  = 17
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [23:0]       s_pixel_tdata,
    input  logic              s_pixel_tvalid,
    output logic              s_pixel_tready,
    input  logic [10:0]       s_hcount,
    input  logic [9:0]        s_vcount,
    input  logic              nf_in,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [11:0]       wr_data,
    output logic              rd_bank,
    output logic              frame_done,
    output logic [15:0]       drop_count,
    output logic              seq_err
);

    localparam logic [10:0]       X_FIRST  = 11'(START_X);
    localparam logic [10:0]       X_LAST   = 11'(END_X - 1);
    localparam logic [10:0]       X_END    = 11'(END_X);
    localparam logic [9:0]        Y_FIRST  = 10'(START_Y);
    localparam logic [9:0]        Y_LAST   = 10'(END_Y - 1);
    localparam logic [9:0]        Y_END    = 10'(END_Y);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(END_X - START_X);
    localparam logic [ADDR_W-1:0] OFF_ONE  = ADDR_W'(1);

    fb_state_t         state_q, state_d;
    logic              swap;
    logic              tready_q;
    logic              rd_bank_q;
    logic [10:0]       x_exp;
    logic [9:0]        y_exp;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_next;
    logic              accept, in_window, match, resync, is_last;
    pixel12_t          pix_q;

    fb_quantize u_quant (
        .rgb  (s_pixel_tdata),
`ifdef FB_DITHER_EN
        .bias (dither_bias({y_exp[0], x_exp[0]})),
`endif
        .q    (pix_q)
    );

    assign accept    = s_pixel_tvalid && tready_q;
    assign in_window = (s_hcount >= X_FIRST) && (s_hcount < X_END) &&
                       (s_vcount >= Y_FIRST) && (s_vcount < Y_END);
    assign match     = in_window && (s_hcount == x_exp) && (s_vcount == y_exp);
    // After a sequence slip the counters only re-lock on the first column of the following row.
    assign resync    = in_window && !match && (s_hcount == X_FIRST) &&
                       (s_vcount == y_exp + 10'd1);
    assign is_last   = (s_hcount == X_LAST) && (s_vcount == Y_LAST);
    assign row_next  = row_base + ROW_STEP;

    // Ready is registered so it stays low throughout reset yet tracks FILL afterwards.
    assign s_pixel_tready = tready_q;
    assign rd_bank        = rd_bank_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept && is_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (nf_in) begin
                    state_d = FILL;
                    swap    = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
            x_exp      <= X_FIRST;
            y_exp      <= Y_FIRST;
            offset     <= '0;
            row_base   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            drop_count <= '0;
            seq_err    <= 1'b0;
        end else begin
            tready_q   <= (state_d == FILL);
            frame_done <= accept && is_last;
            wr_en      <= accept && (match || resync);
            if (swap) begin
                rd_bank_q <= ~rd_bank_q;
                x_exp     <= X_FIRST;
                y_exp     <= Y_FIRST;
                offset    <= '0;
                row_base  <= '0;
            end else if (accept) begin
                if (!in_window) begin
                    if (drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end else if (match) begin
                    wr_addr <= {~rd_bank_q, offset};
                    wr_data <= pix_q;
                    offset  <= offset + OFF_ONE;
                    if (x_exp == X_LAST) begin
                        x_exp    <= X_FIRST;
                        y_exp    <= y_exp + 10'd1;
                        row_base <= row_next;
                    end else begin
                        x_exp <= x_exp + 11'd1;
                    end
                end else if (resync) begin
                    wr_addr  <= {~rd_bank_q, row_next};
                    wr_data  <= pix_q;
                    offset   <= row_next + OFF_ONE;
                    row_base <= row_next;
                    x_exp    <= X_FIRST + 11'd1;
                    y_exp    <= s_vcount;
                end else begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule
